// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM state encoding, instruction/PC+4 entry, constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    // One fetched instruction together with the PC of the following word.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_next;
    } fetch_entry_t;

    // Clear the byte-offset bits so an address always names a whole word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_skid.sv
// One-entry holding register for a fetch that returns while the output slot is stalled.
// Latency: load visible on entry/full the cycle after; unload frees it the cycle after.
// Backpressure: none internally; the owner must only load when empty (clear wins over load).
module if_fetch_skid
    import if_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  fetch_entry_t load_entry,
    output fetch_entry_t entry,
    output logic         full
);

    // Occupancy flag: a clear (redirect) beats a load, a load beats an unload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

    // Payload only changes when a fresh word is parked here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry <= '0;
        end else if (load && !clear) begin
            entry <= load_entry;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, fetches words over req/ready, feeds IF/ID; optional IF_FETCH_ALIGN_CHECK_EN.
// Latency: imem_ready in cycle N -> o_* in N+1; zero-wait memory sustains one word per cycle.
// Backpressure: stall freezes a full slot; one in-flight return parks in the skid and new requests pause.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_PCNext,
    output logic        o_fault
);

    fetch_state_t state;
    fetch_state_t state_nx;
    logic [31:0]  pc;
    logic [31:0]  addr_inc;
    logic         fill;
    logic         slot_free;
    logic         skid_load;
    logic         skid_unload;
    logic         skid_full;
    logic         parked;
    fetch_entry_t skid_entry;
    fetch_entry_t fetch_word;

    assign imem_req = (state != IDLE);

`ifdef IF_FETCH_ALIGN_CHECK_EN
    logic fault;

    // A misaligned redirect target latches the fault until reset and stops fetching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            fault <= 1'b1;
        end
    end

    assign parked  = fault;
    assign o_fault = fault;
`else
    assign parked  = 1'b0;
    assign o_fault = 1'b0;
`endif

    // Routing of a returning word: kept only in REQ without a redirect; slot first, else skid.
    always_comb begin
        addr_inc    = imem_addr + PC_INC;
        fill        = (state == REQ) && imem_ready && !redirect;
        slot_free   = !o_valid || !stall;
        skid_load   = fill && !slot_free;
        skid_unload = !redirect && slot_free && skid_full;
        fetch_word  = '{instr: imem_rdata, pc_next: addr_inc};
    end

    // Next-state logic; redirect outranks everything, a parked skid blocks new requests.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (!redirect && !skid_full && !parked) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_nx = imem_ready ? IDLE : FLUSH;
                end else if (imem_ready && !slot_free) begin
                    state_nx = IDLE;
                end
            end
            FLUSH: begin
                if (imem_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // PC follows redirects and each kept return; the bus address only moves when a new request starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= word_align(RESET_PC);
            imem_addr <= word_align(RESET_PC);
        end else begin
            if (redirect) begin
                pc <= word_align(redirect_pc);
            end else if (fill) begin
                pc <= addr_inc;
            end
            if (state == IDLE && state_nx == REQ) begin
                imem_addr <= pc;
            end else if (fill && slot_free) begin
                imem_addr <= addr_inc;
            end
        end
    end

    // Output slot: cleared by redirect, refilled from the skid before any new return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid       <= 1'b0;
            o_instruction <= NOP_WORD;
            o_PCNext      <= 32'h0;
        end else if (redirect) begin
            o_valid       <= 1'b0;
            o_instruction <= NOP_WORD;
            o_PCNext      <= 32'h0;
        end else if (slot_free) begin
            if (skid_full) begin
                o_valid       <= 1'b1;
                o_instruction <= skid_entry.instr;
                o_PCNext      <= skid_entry.pc_next;
            end else if (fill) begin
                o_valid       <= 1'b1;
                o_instruction <= fetch_word.instr;
                o_PCNext      <= fetch_word.pc_next;
            end else begin
                o_valid       <= 1'b0;
                o_instruction <= NOP_WORD;
                o_PCNext      <= 32'h0;
            end
        end
    end

    if_fetch_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (redirect),
        .load_entry (fetch_word),
        .entry      (skid_entry),
        .full       (skid_full)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: vector table, directed redirect/wrap/alignment cases, randomized run vs stream model.
// Latency: n/a.
// Backpressure: n/a.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic [31:0] o_PCNext;
    logic        o_fault;
    logic [31:0] data_key;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory returns a fixed function of the requested address.
    assign imem_rdata = imem_addr ^ data_key;

    if_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .o_valid       (o_valid),
        .o_instruction (o_instruction),
        .o_PCNext      (o_PCNext),
        .o_fault       (o_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs for the current cycle, then move to the next falling edge.
    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse; leaves the bench on a falling edge with rst just released.
    task automatic do_reset();
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b0;
        rst         = 1'b1;
        #1;
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", o_valid, 1'b0);
        chk("rst_instr", o_instruction, NOP_WORD);
        chk("rst_pcnext", o_PCNext, 32'h0);
        chk1("rst_fault", o_fault, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        st;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pcnext;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcnext;
    } item_t;

    vec_t        vecs[15];
    item_t       exp_q[$];
    logic [31:0] exp_fetch;
    logic [31:0] pend_addr;
    logic        pend;
    logic        discarding;
    int          consumed;

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b0;
        data_key    = 32'h0;

        // Stream from reset, a 3-cycle stall into the skid, then a two-cycle memory wait.
        //            st  rdy req addr   vld instr  pcnext
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00, 32'h04};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04, 32'h08};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08, 32'h0C};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08, 32'h0C};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08, 32'h0C};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08, 32'h0C};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C, 32'h10};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h00, 32'h00};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10, 32'h14};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h14, 32'h18};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b0, 32'h00, 32'h00};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b0, 32'h00, 32'h00};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h18, 32'h1C};

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 15; i++) begin
            chk1($sformatf("tbl%0d_req", i), imem_req, vecs[i].e_req);
            if (vecs[i].e_req) chk($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk1($sformatf("tbl%0d_valid", i), o_valid, vecs[i].e_valid);
            chk($sformatf("tbl%0d_instr", i), o_instruction, vecs[i].e_instr);
            if (vecs[i].e_valid) chk($sformatf("tbl%0d_pcnext", i), o_PCNext, vecs[i].e_pcnext);
            drive(vecs[i].st, 1'b0, 32'h0, vecs[i].rdy);
        end

        // Redirect while the fetch of 0x10 is held waiting: old return dropped, target fetched next.
        do_reset();
        repeat (5) drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk1("fl_req", imem_req, 1'b1);
        chk("fl_addr", imem_addr, 32'h10);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("fl_addr_hold", imem_addr, 32'h10);
        drive(1'b0, 1'b1, 32'h100, 1'b0);
        chk1("fl_bubble", o_valid, 1'b0);
        chk("fl_bubble_pcnext", o_PCNext, 32'h0);
        chk1("fl_req_held", imem_req, 1'b1);
        chk("fl_old_addr", imem_addr, 32'h10);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk1("fl_idle_req", imem_req, 1'b0);
        chk1("fl_dropped", o_valid, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk1("fl_tgt_req", imem_req, 1'b1);
        chk("fl_tgt_addr", imem_addr, 32'h100);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk1("fl_tgt_valid", o_valid, 1'b1);
        chk("fl_tgt_pcnext", o_PCNext, 32'h104);
        chk("fl_tgt_instr", o_instruction, 32'h100);

        // Redirect in the same cycle the memory answers: that word never appears.
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk1("rr_valid0", o_valid, 1'b1);
        chk("rr_pcnext0", o_PCNext, 32'h4);
        drive(1'b0, 1'b1, 32'h200, 1'b1);
        chk1("rr_bubble", o_valid, 1'b0);
        chk("rr_bubble_pcnext", o_PCNext, 32'h0);
        chk1("rr_idle", imem_req, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk1("rr_nodata", o_valid, 1'b0);
        chk("rr_tgt_addr", imem_addr, 32'h200);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk1("rr_tgt_valid", o_valid, 1'b1);
        chk("rr_tgt_pcnext", o_PCNext, 32'h204);

        // Top-of-memory target wraps to zero.
        do_reset();
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk1("wr_idle", imem_req, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wr_pcnext", o_PCNext, 32'h0);
        chk("wr_instr", o_instruction, 32'hFFFF_FFFC);
        chk("wr_next_addr", imem_addr, 32'h0);

        // Misaligned target.
        do_reset();
        drive(1'b0, 1'b1, 32'h102, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef IF_FETCH_ALIGN_CHECK_EN
        chk1("mis_fault", o_fault, 1'b1);
        chk1("mis_parked", imem_req, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk1("mis_still_parked", imem_req, 1'b0);
        chk1("mis_sticky", o_fault, 1'b1);
`else
        chk1("mis_nofault", o_fault, 1'b0);
        chk("mis_aligned_addr", imem_addr, 32'h100);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mis_pcnext", o_PCNext, 32'h104);
`endif

        // Randomized traffic against an in-order stream model.
        do_reset();
        data_key   = 32'h5A5A_C3C3;
        exp_fetch  = 32'h0;
        pend       = 1'b0;
        pend_addr  = 32'h0;
        discarding = 1'b0;
        consumed   = 0;
        exp_q.delete();
        for (int c = 0; c < 2020; c++) begin
            logic        st;
            logic        rd;
            logic        rdy;
            logic [31:0] rpc;
            if (pend) begin
                chk1("rnd_req_hold", imem_req, 1'b1);
                chk("rnd_addr_hold", imem_addr, pend_addr);
            end
            chk1("rnd_valid", o_valid, exp_q.size() != 0);
            if (!o_valid) chk("rnd_empty_nop", o_instruction, NOP_WORD);
            if (imem_req) chk1("rnd_align", imem_addr[1:0] == 2'b00, 1'b1);
            if (c < 2000) begin
                st  = ($urandom_range(9) < 3);
                rd  = ($urandom_range(31) == 0);
                rdy = ($urandom_range(9) < 6);
                rpc = $urandom;
`ifdef IF_FETCH_ALIGN_CHECK_EN
                rpc[1:0] = 2'b00;
`endif
            end else begin
                st  = 1'b0;
                rd  = 1'b0;
                rdy = 1'b1;
                rpc = 32'h0;
            end
            stall       = st;
            redirect    = rd;
            redirect_pc = rpc;
            imem_ready  = rdy;
            if (o_valid && !st && exp_q.size() != 0) begin
                chk("rnd_instr", o_instruction, exp_q[0].instr);
                chk("rnd_pcnext", o_PCNext, exp_q[0].pcnext);
                void'(exp_q.pop_front());
                consumed++;
            end
            if (imem_req && rdy) begin
                if (!discarding && !rd) begin
                    chk("rnd_fetch_addr", imem_addr, exp_fetch);
                    exp_q.push_back(item_t'{instr: exp_fetch ^ data_key, pcnext: exp_fetch + 32'd4});
                    exp_fetch = exp_fetch + 32'd4;
                end
                discarding = 1'b0;
            end
            if (rd) begin
                exp_q.delete();
                exp_fetch = rpc & 32'hFFFF_FFFC;
                if (imem_req && !rdy) discarding = 1'b1;
            end
            pend      = imem_req && !rdy;
            pend_addr = imem_addr;
            @(negedge clk);
        end
        chk1("rnd_progress", consumed >= 100, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
